// File: rtl/cfg_bitstream_tx.sv
// cfg_bitstream_tx: shifts configuration words out MSB first as {word, SYNC_WORD} frames and closes the
// session with END_WORD. Define CFG_TX_ALIAS_CHECK_EN to add the sticky alias_err marker-alias detector.
module cfg_bitstream_tx #(
  parameter int          WORD_W    = 32,
  parameter logic [15:0] SYNC_WORD = 16'hFAB2,
  parameter logic [15:0] END_WORD  = 16'hFAB3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic              tx_data,
  output logic              tx_active,
  output logic              done,
  output logic              underrun
`ifdef CFG_TX_ALIAS_CHECK_EN
  ,
  output logic              alias_err
`endif
);

  localparam int         FRAME_W    = WORD_W + 16;
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_W - 1);
  localparam logic [5:0] END_LAST   = 6'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_END   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [5:0]         cnt_r, cnt_s;
  logic [FRAME_W-1:0] shift_r, shift_s;
  logic               tx_data_r, tx_data_s;
  logic               last_r, last_s;
  logic               done_r, done_s;
  logic               underrun_r, underrun_s;
  logic               tx_active_r, tx_active_s;
  logic               accept_s;
  logic [FRAME_W-1:0] frame_load_s;
  logic [FRAME_W-1:0] end_load_s;

  // The first bit goes straight into tx_data on the load edge, so the shift register keeps only the rest.
  assign frame_load_s = {word_in[WORD_W-2:0], SYNC_WORD, 1'b0};
  assign end_load_s   = {END_WORD[14:0], {(FRAME_W - 15){1'b0}}};

  assign word_ready = reset & (((state_r == ST_IDLE) & ~done_r) |
                               ((state_r == ST_FRAME) & (cnt_r == FRAME_LAST) & ~last_r));
  assign accept_s   = word_valid & word_ready;
  assign tx_active_s = (state_s == ST_FRAME) | (state_s == ST_END);

  // Next-state, next-bit and sticky-flag logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    shift_s    = shift_r;
    tx_data_s  = tx_data_r;
    last_s     = last_r;
    done_s     = done_r;
    underrun_s = underrun_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s   = ST_FRAME;
          cnt_s     = 6'd0;
          shift_s   = frame_load_s;
          tx_data_s = word_in[WORD_W-1];
          last_s    = word_last;
        end else begin
          tx_data_s = 1'b0;
        end
      end
      ST_FRAME: begin
        if (cnt_r != FRAME_LAST) begin
          cnt_s     = cnt_r + 6'd1;
          shift_s   = {shift_r[FRAME_W-2:0], 1'b0};
          tx_data_s = shift_r[FRAME_W-1];
        end else if (accept_s) begin
          cnt_s     = 6'd0;
          shift_s   = frame_load_s;
          tx_data_s = word_in[WORD_W-1];
          last_s    = word_last;
        end else if (last_r) begin
          state_s   = ST_END;
          cnt_s     = 6'd0;
          shift_s   = end_load_s;
          tx_data_s = END_WORD[15];
        end else begin
          // Source starved mid-session: flag it but keep the session open.
          state_s    = ST_IDLE;
          cnt_s      = 6'd0;
          tx_data_s  = 1'b0;
          underrun_s = 1'b1;
        end
      end
      ST_END: begin
        if (cnt_r != END_LAST) begin
          cnt_s     = cnt_r + 6'd1;
          shift_s   = {shift_r[FRAME_W-2:0], 1'b0};
          tx_data_s = shift_r[FRAME_W-1];
        end else begin
          state_s   = ST_DONE;
          cnt_s     = 6'd0;
          tx_data_s = 1'b0;
          done_s    = 1'b1;
        end
      end
      ST_DONE: begin
        tx_data_s = 1'b0;
        done_s    = 1'b1;
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = 6'd0;
        tx_data_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 6'd0;
      shift_r     <= {FRAME_W{1'b0}};
      tx_data_r   <= 1'b0;
      last_r      <= 1'b0;
      done_r      <= 1'b0;
      underrun_r  <= 1'b0;
      tx_active_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      shift_r     <= shift_s;
      tx_data_r   <= tx_data_s;
      last_r      <= last_s;
      done_r      <= done_s;
      underrun_r  <= underrun_s;
      tx_active_r <= tx_active_s;
    end
  end

  assign tx_data   = tx_data_r;
  assign tx_active = tx_active_r;
  assign done      = done_r;
  assign underrun  = underrun_r;

`ifdef CFG_TX_ALIAS_CHECK_EN
  logic [14:0] hist_r;
  logic [15:0] window_s;
  logic        marker_end_s;
  logic        alias_hit_s;
  logic        alias_err_r;

  // Window ends with the bit currently on the pin; only a marker's own final bit may complete a match.
  assign window_s     = {hist_r, tx_data_r};
  assign marker_end_s = ((state_r == ST_FRAME) & (cnt_r == FRAME_LAST)) |
                        ((state_r == ST_END) & (cnt_r == END_LAST));
  assign alias_hit_s  = ((window_s == SYNC_WORD) | (window_s == END_WORD)) & ~marker_end_s;

  // Emitted-bit history and sticky alias flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_r      <= 15'd0;
      alias_err_r <= 1'b0;
    end else begin
      hist_r      <= window_s[14:0];
      alias_err_r <= alias_err_r | alias_hit_s;
    end
  end

  assign alias_err = alias_err_r;
`endif

endmodule
